shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier (MUL/MULH/MULHSU/MULHU), one partial product per cycle.
// Optional MUL_EARLY_TERM_EN: exit when the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               mul_resp
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 resp_q, resp_d;

  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;

  // Negating in WIDTH bits maps -2^(WIDTH-1) onto 2^(WIDTH-1) as an unsigned magnitude.
  always_comb begin
    a_signed = (op != 2'b11);
    b_signed = (op[1] == 1'b0);
    a_neg    = a_signed & multiplicand[WIDTH-1];
    b_neg    = b_signed & multiplier[WIDTH-1];
    mag_a    = a_neg ? (~multiplicand + 1'b1) : multiplicand;
    mag_b    = b_neg ? (~multiplier + 1'b1) : multiplier;
  end

  always_comb begin
    acc_sum = acc_q + (b_q[0] ? a_q : '0);
`ifdef MUL_EARLY_TERM_EN
    last_iter = (cnt_q == LAST_ITER) || (b_q[WIDTH-1:1] == '0);
`else
    last_iter = (cnt_q == LAST_ITER);
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          neg_d     = a_neg ^ b_neg;
          a_d       = {{WIDTH{1'b0}}, mag_a};
          b_d       = mag_b;
          acc_d     = '0;
          cnt_d     = '0;
          product_d = '0;
`ifdef MUL_EARLY_TERM_EN
          state_d   = ((mag_a == '0) || (mag_b == '0)) ? DONE : CALC;
`else
          state_d   = CALC;
`endif
        end
      end
      CALC: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d   = DONE;
          product_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    resp_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      neg_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      resp_q    <= resp_d;
    end
  end

  assign product  = product_q;
  assign result   = (op_q == 2'b00) ? product_q[WIDTH-1:0] : product_q[2*WIDTH-1:WIDTH];
  assign busy     = busy_q;
  assign mul_resp = resp_q;

endmodule
